// File: rtl/rx_packet_slot_writer.sv
// rx_packet_slot_writer
// Sinks an 8-bit Avalon-ST receive stream and packs each packet little-endian into
// 32-bit RAM words. The RAM is split into 2^SLOT_W equal slots; word 0 of a slot is a
// header {11'b0, rx_err, byte_length} and the packet data follows from word 1.
// Packets are dropped (and counted) when the target slot is still owned by the
// consumer, when they exceed the slot capacity, when a new SOP arrives before EOP, or
// (optionally) when the MAC flags an error on the EOP beat.
module rx_packet_slot_writer #(
    parameter int unsigned ADDR_W      = 11,
    parameter int unsigned SLOT_W      = 2,
    parameter bit          DROP_ON_ERR = 1'b1
) (
    input  logic                      clk_original,
    input  logic                      rst,
    input  logic [7:0]                ff_rx_data,
    input  logic                      ff_rx_sop,
    input  logic                      ff_rx_eop,
    input  logic                      ff_rx_dval,
    input  logic [4:0]                rx_err,
    output logic                      ff_rx_rdy,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic                      ram_chipselect,
    output logic                      ram_write,
    output logic [31:0]               ram_writedata,
    output logic [3:0]                ram_byteenable,
    output logic [(1 << SLOT_W)-1:0]  slot_ready,
    input  logic                      slot_release,
    input  logic [SLOT_W-1:0]         slot_release_idx,
    output logic                      pkt_done,
    output logic [15:0]               drop_cnt
);

    // Word offset width inside a slot, slot count and byte capacity of one slot.
    localparam int unsigned OFF_W = ADDR_W - SLOT_W;
    localparam int unsigned NSLOT = 1 << SLOT_W;
    localparam int unsigned CAP   = 4 * ((1 << OFF_W) - 1);

    localparam logic [15:0]      CAP_CNT  = 16'(CAP);
    localparam logic [NSLOT-1:0] SLOT_ONE = {{(NSLOT-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        StIdle,
        StRecv,
        StFlush,
        StHdr,
        StDrop
    } state_e;

    state_e r_state;
    state_e w_state_next;

    logic [SLOT_W-1:0] r_wr_slot;
    logic [15:0]       r_count;
    logic [31:0]       r_lanes;
    logic [4:0]        r_err;
    logic [NSLOT-1:0]  r_slot_ready;
    logic [15:0]       r_drop_cnt;
    logic              r_ram_write;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [31:0]       r_ram_wdata;
    logic [3:0]        r_ram_be;
    logic              r_pkt_done;

    logic              w_rdy;
    logic              w_accept;
    logic              w_sop;
    logic              w_eop;
    logic              w_slot_busy;
    logic              w_restart;
    logic              w_abort;
    logic              w_busy_drop;
    logic              w_overflow;
    logic              w_store;
    logic              w_err_drop;
    logic              w_flush_drop;
    logic              w_drop_inc;
    logic              w_word_write;
    logic [15:0]       w_byte_idx;
    logic [15:0]       w_count_new;
    logic [1:0]        w_lane;
    logic [31:0]       w_lanes_new;
    logic [3:0]        w_part_be;
    logic [OFF_W-1:0]  w_data_off;
    logic [NSLOT-1:0]  w_rel_mask;
    logic [NSLOT-1:0]  w_set_mask;

    // Beat qualification and per-beat decisions shared by the FSM and the datapath.
    assign w_accept    = ff_rx_dval & w_rdy;
    assign w_sop       = w_accept & ff_rx_sop;
    assign w_eop       = w_accept & ff_rx_eop;
    assign w_slot_busy = r_slot_ready[r_wr_slot];

    // A new packet starts in the current slot from IDLE (slot free) or from RECV,
    // where it replaces the unterminated packet that was in progress.
    assign w_restart   = w_sop & (((r_state == StIdle) & ~w_slot_busy) | (r_state == StRecv));
    assign w_abort     = w_sop & (r_state == StRecv);
    assign w_busy_drop = w_sop & (r_state == StIdle) & w_slot_busy;
    assign w_overflow  = w_accept & ~ff_rx_sop & (r_state == StRecv) & (r_count >= CAP_CNT);
    assign w_store     = w_restart
                       | (w_accept & ~ff_rx_sop & (r_state == StRecv) & (r_count < CAP_CNT));

    assign w_byte_idx  = w_restart ? 16'd0 : r_count;
    assign w_count_new = w_byte_idx + 16'd1;
    assign w_lane      = w_byte_idx[1:0];
    assign w_data_off  = OFF_W'(1) + w_byte_idx[OFF_W+1:2];

    assign w_err_drop   = w_store & ff_rx_eop & DROP_ON_ERR & (rx_err != 5'd0);
    assign w_flush_drop = DROP_ON_ERR & (r_err != 5'd0);
    assign w_drop_inc   = w_busy_drop | w_abort | w_overflow | w_err_drop;

    // A word goes out when its top lane fills or when EOP leaves it partial.
    assign w_word_write = w_store & ((w_lane == 2'd3) | ff_rx_eop);

    assign w_rel_mask = slot_release ? (SLOT_ONE << slot_release_idx) : '0;
    assign w_set_mask = (r_state == StHdr) ? (SLOT_ONE << r_wr_slot) : '0;

    // Merge the incoming byte into the word being assembled; lane 0 starts a fresh word.
    always_comb begin
        w_lanes_new = r_lanes;
        if (w_lane == 2'd0) begin
            w_lanes_new = {24'h000000, ff_rx_data};
        end else begin
            w_lanes_new[{w_lane, 3'b000} +: 8] = ff_rx_data;
        end
    end

    // Byte enables for the word being written, from the byte count after this beat.
    always_comb begin
        w_part_be = 4'b1111;
        case (w_count_new[1:0])
            2'd1:    w_part_be = 4'b0001;
            2'd2:    w_part_be = 4'b0011;
            2'd3:    w_part_be = 4'b0111;
            default: w_part_be = 4'b1111;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_original) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (w_sop) begin
                    if (w_slot_busy) begin
                        w_state_next = ff_rx_eop ? StIdle : StDrop;
                    end else begin
                        w_state_next = ff_rx_eop ? StFlush : StRecv;
                    end
                end
            end
            StRecv: begin
                if (w_accept) begin
                    if (ff_rx_sop) begin
                        w_state_next = ff_rx_eop ? StFlush : StRecv;
                    end else if (w_overflow) begin
                        w_state_next = ff_rx_eop ? StIdle : StDrop;
                    end else if (ff_rx_eop) begin
                        w_state_next = StFlush;
                    end
                end
            end
            StFlush: w_state_next = w_flush_drop ? StIdle : StHdr;
            StHdr:   w_state_next = StIdle;
            StDrop: begin
                if (w_eop) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // FSM outputs: the stream is back-pressured only while the tail and header go out.
    always_comb begin
        w_rdy = 1'b0;
        if (!rst) begin
            case (r_state)
                StIdle, StRecv, StDrop: w_rdy = 1'b1;
                default:                w_rdy = 1'b0;
            endcase
        end
    end

    // Datapath: byte packing, registered RAM writes, slot ownership and drop counting.
    always_ff @(posedge clk_original) begin
        if (rst) begin
            r_wr_slot    <= '0;
            r_count      <= '0;
            r_lanes      <= '0;
            r_err        <= '0;
            r_slot_ready <= '0;
            r_drop_cnt   <= '0;
            r_ram_write  <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
            r_ram_be     <= '0;
            r_pkt_done   <= 1'b0;
        end else begin
            r_ram_write <= 1'b0;
            r_pkt_done  <= 1'b0;

            if (w_store) begin
                r_count <= w_count_new;
                r_lanes <= w_lanes_new;
            end
            if (w_store && ff_rx_eop) begin
                r_err <= rx_err;
            end

            if (w_word_write) begin
                r_ram_write <= 1'b1;
                r_ram_addr  <= {r_wr_slot, w_data_off};
                r_ram_wdata <= w_lanes_new;
                r_ram_be    <= w_part_be;
            end else if ((r_state == StFlush) && !w_flush_drop) begin
                // Header lands in the HDR cycle, together with pkt_done.
                r_ram_write <= 1'b1;
                r_ram_addr  <= {r_wr_slot, {OFF_W{1'b0}}};
                r_ram_wdata <= {11'd0, r_err, r_count};
                r_ram_be    <= 4'b1111;
                r_pkt_done  <= 1'b1;
            end

            if (w_drop_inc && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end

            if (r_state == StHdr) begin
                r_wr_slot <= r_wr_slot + 1'b1;
            end

            // A commit and a release of the same slot in one cycle leave it set.
            r_slot_ready <= (r_slot_ready & ~w_rel_mask) | w_set_mask;
        end
    end

    assign ff_rx_rdy      = w_rdy;
    assign ram_addr       = r_ram_addr;
    assign ram_write      = r_ram_write;
    assign ram_chipselect = r_ram_write;
    assign ram_writedata  = r_ram_wdata;
    assign ram_byteenable = r_ram_be;
    assign slot_ready     = r_slot_ready;
    assign pkt_done       = r_pkt_done;
    assign drop_cnt       = r_drop_cnt;

endmodule

// File: tb/tb_rx_packet_slot_writer.sv
// Bench for rx_packet_slot_writer: two instances (drop-on-error and keep-on-error) see
// the same stream; a packet-level model predicts RAM contents, slot ownership, drop and
// commit counts for each.
module tb_rx_packet_slot_writer;

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned SLOT_W = 2;
    localparam int unsigned WORDS  = 1 << ADDR_W;
    localparam int unsigned S      = WORDS >> SLOT_W;
    localparam int unsigned CAP    = 4 * (S - 1);
    localparam logic [31:0] FILL   = 32'hA5A5_A5A5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [7:0]        data;
    logic              sop;
    logic              eop;
    logic              dval;
    logic [4:0]        err;
    logic              rel;
    logic [SLOT_W-1:0] rel_idx;

    logic              rdy0, rdy1, wr0, wr1, cs0, cs1, done0, done1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [31:0]       wd0, wd1;
    logic [3:0]        be0, be1, sr0, sr1;
    logic [15:0]       drop0, drop1;
    logic [1:0]        rdy;
    assign rdy = {rdy1, rdy0};

    rx_packet_slot_writer #(.ADDR_W(ADDR_W), .SLOT_W(SLOT_W), .DROP_ON_ERR(1'b1)) dut_drop (
        .clk_original(clk), .rst(rst), .ff_rx_data(data), .ff_rx_sop(sop), .ff_rx_eop(eop),
        .ff_rx_dval(dval), .rx_err(err), .ff_rx_rdy(rdy0), .ram_addr(addr0),
        .ram_chipselect(cs0), .ram_write(wr0), .ram_writedata(wd0), .ram_byteenable(be0),
        .slot_ready(sr0), .slot_release(rel), .slot_release_idx(rel_idx), .pkt_done(done0),
        .drop_cnt(drop0)
    );

    rx_packet_slot_writer #(.ADDR_W(ADDR_W), .SLOT_W(SLOT_W), .DROP_ON_ERR(1'b0)) dut_keep (
        .clk_original(clk), .rst(rst), .ff_rx_data(data), .ff_rx_sop(sop), .ff_rx_eop(eop),
        .ff_rx_dval(dval), .rx_err(err), .ff_rx_rdy(rdy1), .ram_addr(addr1),
        .ram_chipselect(cs1), .ram_write(wr1), .ram_writedata(wd1), .ram_byteenable(be1),
        .slot_ready(sr1), .slot_release(rel), .slot_release_idx(rel_idx), .pkt_done(done1),
        .drop_cnt(drop1)
    );

    // RAM behind each instance plus write/commit/chipselect bookkeeping.
    logic [31:0] act_mem [2][WORDS];
    logic        mem_init;
    int          n_wr [2];
    int          n_done [2];
    int          cs_bad;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = nw[8*k +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < WORDS; i++) begin
                act_mem[0][i] <= FILL;
                act_mem[1][i] <= FILL;
            end
            n_wr[0] <= 0; n_wr[1] <= 0; n_done[0] <= 0; n_done[1] <= 0; cs_bad <= 0;
        end else begin
            if (wr0) begin
                act_mem[0][addr0] <= merge(act_mem[0][addr0], wd0, be0);
                n_wr[0] <= n_wr[0] + 1;
            end
            if (wr1) begin
                act_mem[1][addr1] <= merge(act_mem[1][addr1], wd1, be1);
                n_wr[1] <= n_wr[1] + 1;
            end
            if (done0) n_done[0] <= n_done[0] + 1;
            if (done1) n_done[1] <= n_done[1] + 1;
            if ((cs0 !== wr0) || (cs1 !== wr1)) cs_bad <= cs_bad + 1;
        end
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- packet-level reference model ----------------
    logic [31:0] exp_mem [2][WORDS];
    logic [3:0]  m_ready [2];
    int          m_slot [2];
    int          m_drop [2];
    int          exp_wr [2];
    int          exp_done [2];
    logic [7:0]  pkt_bytes [$];

    task automatic m_drop_inc(input int d);
        if (m_drop[d] < 65535) m_drop[d]++;
    endtask

    // Store the first n bytes of pkt_bytes into slot base of instance d.
    task automatic m_store(input int d, input int n);
        int base;
        base = m_slot[d] * S;
        for (int i = 0; i < n; i++) exp_mem[d][base + 1 + i / 4][8 * (i % 4) +: 8] = pkt_bytes[i];
    endtask

    task automatic model_packet(input int len, input logic [4:0] e);
        int n;
        for (int d = 0; d < 2; d++) begin
            if (m_ready[d][m_slot[d]]) begin
                m_drop_inc(d);
            end else begin
                n = (len > CAP) ? CAP : len;
                m_store(d, n);
                exp_wr[d] += (n + 3) / 4;
                if (len > CAP || (d == 0 && e != 5'd0)) begin
                    m_drop_inc(d);
                end else begin
                    exp_mem[d][m_slot[d] * S] = {11'd0, e, 16'(len)};
                    exp_wr[d]++;
                    exp_done[d]++;
                    m_ready[d][m_slot[d]] = 1'b1;
                    m_slot[d] = (m_slot[d] + 1) % 4;
                end
            end
        end
    endtask

    // An unterminated prefix (slot free): only its complete words reach RAM.
    task automatic model_prefix(input int n, input bit counted);
        for (int d = 0; d < 2; d++) begin
            m_store(d, (n / 4) * 4);
            exp_wr[d] += n / 4;
            if (counted) m_drop_inc(d);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ready[d] = 4'd0;
            m_slot[d]  = 0;
            m_drop[d]  = 0;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic fill_bytes(input int n, input bit ramp);
        pkt_bytes.delete();
        for (int i = 0; i < n; i++) pkt_bytes.push_back(ramp ? 8'(i) : 8'($urandom));
    endtask

    task automatic send_pkt(input int n, input bit with_sop, input bit with_eop,
                            input logic [4:0] e, input bit gaps, input bit chk_lat,
                            input int lat_base);
        int t;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (chk_lat && i == 4) begin
                check_val("lat_write", 32'(wr0), 32'd1);
                check_val("lat_addr", 32'(addr0), 32'(lat_base + 1));
                check_val("lat_be", 32'(be0), 32'hF);
            end
            if (i == 0) begin
                dval = 1'b0;
                t = 0;
                while (rdy != 2'b11 && t < 20) begin
                    @(negedge clk);
                    t++;
                end
                if (t >= 20) check_val("rdy_timeout", 32'(rdy), 32'h3);
            end
            if (gaps && $urandom_range(3) == 0) begin
                dval = 1'b0;
                repeat (1 + $urandom_range(1)) @(negedge clk);
            end
            dval = 1'b1;
            data = pkt_bytes[i];
            sop  = with_sop && (i == 0);
            eop  = with_eop && (i == n - 1);
            err  = eop ? e : 5'($urandom);
        end
        @(negedge clk);
        dval = 1'b0; sop = 1'b0; eop = 1'b0;
    endtask

    task automatic junk(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            dval = 1'b1; sop = 1'b0; eop = 1'($urandom); data = 8'($urandom);
        end
        @(negedge clk);
        dval = 1'b0; eop = 1'b0;
    endtask

    task automatic release_slot(input int idx);
        @(negedge clk);
        rel = 1'b1; rel_idx = SLOT_W'(idx);
        @(negedge clk);
        rel = 1'b0;
        m_ready[0][idx] = 1'b0;
        m_ready[1][idx] = 1'b0;
    endtask

    task automatic compare_all();
        int diffs [2];
        repeat (4) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            diffs[d] = 0;
            for (int i = 0; i < WORDS; i++) if (act_mem[d][i] !== exp_mem[d][i]) diffs[d]++;
        end
        check_val("mem_drop_diffs", 32'(diffs[0]), 32'd0);
        check_val("mem_keep_diffs", 32'(diffs[1]), 32'd0);
        check_val("slot_ready_drop", 32'(sr0), 32'(m_ready[0]));
        check_val("slot_ready_keep", 32'(sr1), 32'(m_ready[1]));
        check_val("drop_cnt_drop", 32'(drop0), 32'(m_drop[0]));
        check_val("drop_cnt_keep", 32'(drop1), 32'(m_drop[1]));
        check_val("writes_drop", 32'(n_wr[0]), 32'(exp_wr[0]));
        check_val("writes_keep", 32'(n_wr[1]), 32'(exp_wr[1]));
        check_val("pkt_done_drop", 32'(n_done[0]), 32'(exp_done[0]));
        check_val("pkt_done_keep", 32'(n_done[1]), 32'(exp_done[1]));
    endtask

    task automatic send_and_model(input int len, input logic [4:0] e, input bit gaps);
        send_pkt(len, 1'b1, 1'b1, e, gaps, 1'b0, 0);
        model_packet(len, e);
        compare_all();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        int len;
        int r;
        logic [4:0] e;

        rst = 1'b1; dval = 1'b0; sop = 1'b0; eop = 1'b0; data = 8'd0; err = 5'd0;
        rel = 1'b0; rel_idx = '0; mem_init = 1'b1;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < WORDS; i++) exp_mem[d][i] = FILL;
            exp_wr[d] = 0;
            exp_done[d] = 0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        mem_init = 1'b0;
        check_val("reset_rdy", 32'(rdy), 32'd0);
        check_val("reset_slot_ready", 32'(sr0), 32'd0);
        check_val("reset_drop_cnt", 32'(drop0), 32'd0);
        check_val("reset_write", 32'({wr1, wr0}), 32'd0);
        check_val("reset_pkt_done", 32'({done1, done0}), 32'd0);
        rst = 1'b0;
        #1 check_val("rdy_after_reset", 32'(rdy), 32'h3);

        // 60-byte ramp into slot 0, with write-latency check on the first word.
        fill_bytes(60, 1'b1);
        send_pkt(60, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 0);
        model_packet(60, 5'd0);
        compare_all();
        check_val("t1_word1", act_mem[0][1], 32'h03020100);
        check_val("t1_header", act_mem[0][0], 32'h0000003C);

        // 61 bytes: partial tail word and two back-pressure cycles after EOP.
        fill_bytes(61, 1'b1);
        send_pkt(61, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 0);
        cnt = 0;
        while (rdy != 2'b11 && cnt < 10) begin
            cnt++;
            @(negedge clk);
        end
        check_val("t2_rdy_low_cycles", 32'(cnt), 32'd2);
        model_packet(61, 5'd0);
        compare_all();
        check_val("t2_tail_word", act_mem[0][S + 16], 32'hA5A5A53C);
        check_val("t2_header", act_mem[0][S], 32'h0000003D);

        // Fill the remaining slots, overflow by one, then release slot 0 and reuse it.
        for (int p = 0; p < 3; p++) begin
            fill_bytes(8 + p, 1'b0);
            send_and_model(8 + p, 5'd0, 1'b1);
        end
        check_val("t3_all_ready", 32'(sr0), 32'hF);
        check_val("t3_one_drop", 32'(drop0), 32'd1);
        release_slot(0);
        fill_bytes(33, 1'b0);
        send_and_model(33, 5'd0, 1'b0);
        check_val("t3_reuse_header", act_mem[0][0], 32'h00000021);

        // Oversize packet, then a normal one into the same slot.
        for (int s = 0; s < 4; s++) release_slot(s);
        fill_bytes(CAP + 1, 1'b0);
        send_and_model(CAP + 1, 5'd0, 1'b0);
        check_val("t5_drop_cnt", 32'(drop0), 32'd2);
        fill_bytes(64, 1'b0);
        send_and_model(64, 5'd0, 1'b0);

        // SOP before EOP: prefix aborted, new packet restarts in the same slot.
        fill_bytes(10, 1'b0);
        send_pkt(10, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 0);
        model_prefix(10, 1'b1);
        fill_bytes(20, 1'b0);
        send_and_model(20, 5'd0, 1'b0);

        // Reset in the middle of a packet.
        fill_bytes(13, 1'b0);
        send_pkt(13, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 0);
        model_prefix(13, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1 check_val("t6_rdy_in_reset", 32'(rdy), 32'd0);
        @(posedge clk);
        #1;
        check_val("t6_slot_ready_cleared", 32'({sr1, sr0}), 32'd0);
        check_val("t6_drop_cleared", 32'({drop1, drop0}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1 check_val("t6_rdy_after", 32'(rdy), 32'h3);
        fill_bytes(64, 1'b0);
        send_and_model(64, 5'd0, 1'b0);

        // Errored packet: dropped by one instance, committed with status by the other.
        for (int s = 0; s < 4; s++) release_slot(s);
        fill_bytes(37, 1'b0);
        send_and_model(37, 5'b00010, 1'b0);
        check_val("t4_keep_header", act_mem[1][S], 32'h00020025);
        check_val("t4_drop_drop_cnt", 32'(drop0), 32'd1);

        // Randomised traffic with random releases and stray beats.
        for (int it = 0; it < 40; it++) begin
            for (int s = 0; s < 4; s++) if ($urandom_range(1) == 1) release_slot(s);
            if ($urandom_range(3) == 0) junk($urandom_range(3, 1));
            r = $urandom_range(9);
            if (r < 3)      len = $urandom_range(8, 1);
            else if (r < 8) len = $urandom_range(200, 9);
            else if (r == 8) len = $urandom_range(CAP, 201);
            else            len = $urandom_range(CAP + 3, CAP + 1);
            e = ($urandom_range(4) == 0) ? 5'($urandom_range(31, 1)) : 5'd0;
            fill_bytes(len, 1'b0);
            send_and_model(len, e, 1'b1);
        end

        check_val("chipselect_eq_write", 32'(cs_bad), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/rx_packet_slot_writer.md
Name: rx_packet_slot_writer

Overview:
Parametrised successor to the MAC receive-to-RAM writer. It sinks 8-bit Avalon-ST frames from the MAC receive FIFO and packs bytes little-endian into 32-bit RAM words. The RAM is split into 2^SLOT_W equal packet slots, each prefixed by a header word giving length and status. Errored, oversize and no-free-slot packets are dropped and counted; the consumer (CPU/DMA) frees slots by releasing them.

Parameters:
ADDR_W, 11, RAM word-address width; total RAM = 2^ADDR_W words; legal range 4..14.
SLOT_W, 2, log2 of slot count; slot size S = 2^(ADDR_W-SLOT_W) words; SLOT_W < ADDR_W-1.
DROP_ON_ERR, 1, 1: discard packets with nonzero rx_err at EOP; 0: commit them with error bits in the header.

Ports:
clk_original  in  1  single clock.
rst  in  1  synchronous, active-high reset.
ff_rx_data  in  8  stream byte.
ff_rx_sop  in  1  start of packet.
ff_rx_eop  in  1  end of packet.
ff_rx_dval  in  1  byte valid.
rx_err  in  5  MAC error flags, sampled on the EOP beat.
ff_rx_rdy  out  1  ready; a beat is accepted when dval && rdy.
ram_addr  out  ADDR_W  word address.
ram_chipselect  out  1  equal to ram_write.
ram_write  out  1  single-cycle write strobe.
ram_writedata  out  32  write data; byte k of the packet occupies lane k mod 4.
ram_byteenable  out  4  valid lanes for this write.
slot_ready  out  2^SLOT_W  bit i high = slot i holds a committed packet.
slot_release  in  1  one-cycle pulse that frees a slot.
slot_release_idx  in  SLOT_W  index of the slot to free.
pkt_done  out  1  one-cycle pulse on each commit.
drop_cnt  out  16  count of dropped packets; saturates at 0xFFFF.

Behaviour:
- Reset: all outputs 0, including ff_rx_rdy, slot_ready and drop_cnt. wr_slot=0. State=IDLE. ff_rx_rdy rises the first cycle after rst deasserts.
- Slot layout:
  - base = wr_slot*S.
  - Header at base+0: [15:0] byte length, [20:16] rx_err, [31:21] 0.
  - Data words at base+1 .. base+S-1.
  - Capacity C = 4*(S-1) bytes (2044 at defaults).
- ff_rx_rdy=1 in IDLE, RECV and DROP; 0 in FLUSH and HDR.
- States:
  - IDLE:
    - Beats without sop are ignored.
    - sop with slot_ready[wr_slot]=0 goes to RECV: byte count=1, byte latched in lane 0.
    - sop with slot_ready[wr_slot]=1 goes to DROP and drop_cnt+1. If sop&&eop on that beat, drop_cnt+1 and stay in IDLE.
  - RECV: each accepted byte goes into lane (count mod 4), and count+1.
    - When lane 3 fills: next cycle, ram_write=1, addr=base+1+word_idx, byteenable=1111.
    - On eop: latch rx_err, go to FLUSH.
    - Accepting byte C+1: go to DROP, drop_cnt+1, slot not committed.
    - sop again (missing EOP): current packet is aborted, drop_cnt+1, and the new packet restarts in the same slot at count=1.
  - FLUSH (1 cycle):
    - Writes any pending full or partial word; byteenable has low bits set for the valid lanes only (count mod 4=1 gives 0001, 2 gives 0011, 3 gives 0111).
    - If no word is pending, it is an idle cycle.
    - Next state: HDR, or IDLE if the packet is dropped for error.
  - HDR (1 cycle):
    - Write header at base+0, byteenable=1111, pkt_done=1.
    - Next cycle: slot_ready[wr_slot]=1, wr_slot=(wr_slot+1) mod 2^SLOT_W, go to IDLE.
  - DROP: accepts and discards beats until eop, then goes to IDLE.
    - sop inside DROP is discarded too.
    - No RAM writes occur in DROP.
- Error drop: with DROP_ON_ERR=1 and nonzero rx_err on the eop beat, the header is not written, the slot is not committed, drop_cnt+1 and wr_slot is unchanged. Data words already written are left in RAM and are harmless.
- Release: on slot_release, slot_ready[idx] clears the next cycle. Releasing a bit that is already clear is a no-op. Set and release of the same index in the same cycle: set wins.
- Write latency: exactly 1 cycle from accepting the 4th byte of a word to its ram_write. At most one write per cycle; RAM always accepts (no waitrequest).
- rst mid-packet: abandons the packet and clears all slots and counters.

Test Plan:
1. 60-byte packet, bytes 0x00..0x3B, into empty RAM -> 15 writes at addr 1..15 with byteenable 1111; word at addr 1 = 0x03020100; header at addr 0 = 0x0000003C; pkt_done one pulse; slot_ready=0001.
2. 61-byte packet -> last data write at addr 16 with byteenable 0001 and data 0x3C in lane 0; header=0x0000003D; ff_rx_rdy low for exactly 2 cycles after eop.
3. 5 packets back-to-back with no release -> slots 0..3 at bases 0, 512, 1024, 1536; 5th dropped; drop_cnt=1; slot_ready=1111. Release idx 0, then send a 6th packet -> it lands at base 0.
4. rx_err=5'b00010 on eop, DROP_ON_ERR=1 -> no header write, slot_ready unchanged, drop_cnt+1. Same with DROP_ON_ERR=0 -> header=0x0002xxxx with correct length.
5. 2045-byte packet -> data writes stop at addr 511, drop_cnt+1, no header. The following 64-byte packet reuses slot 0.
6. sop mid-packet and rst asserted mid-packet -> abort with drop_cnt+1 and restart at base+1. rst clears slot_ready, drop_cnt and ff_rx_rdy in the same cycle.
